// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Macro DIV_SIGNED_EN (consumed by seq_divider_param) enables the FIX state.
package div_pkg;

    // Upper bound on the divider width; the all-ones helper is sized to it.
    localparam int MAX_WIDTH = 32;

    // FIX is only visited when signed operation is compiled in.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Quotient reported for a zero divisor: all ones in the low 'width' bits.
    function automatic logic [MAX_WIDTH-1:0] dz_quotient(input int width);
        return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
    endfunction

endpackage

// File: rtl/seq_divider_param_if.sv
// Operand and result channels of seq_divider_param.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// A source holds valid and its payload stable until that edge; ready may
// toggle freely and is never required before valid is raised.
interface seq_divider_param_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;

    // Requester side: supplies operands, consumes results.
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );

    // Divider side.
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   p_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   p_o,
    output logic             q_o
);

    // The stored remainder is always below the divisor, so its MSB is zero;
    // it still takes part in the compare to keep the step exact.
    always_comb begin
        q_o = ({p_i, bit_i} >= {2'b00, divisor_i});
        p_o = q_o ? (WIDTH+1)'({p_i, bit_i} - {2'b00, divisor_i})
                  : {p_i[WIDTH-1:0], bit_i};
    end

endmodule

// File: rtl/seq_divider_param.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on
// both the operand and the result channel.
// Optional macro DIV_SIGNED_EN: two's-complement operands with a 1-cycle
// FIX state that applies the result signs (truncation toward zero).
module seq_divider_param
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    seq_divider_param_if.slave  bus,
    output div_state_e          state_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [MAX_WIDTH-1:0] DZ_ALL = dz_quotient(WIDTH);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dvd_q;       // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dsr_q;       // divisor (magnitude in signed builds)
    logic [WIDTH:0]   p_q;         // partial remainder
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_by_zero_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             busy_q;

    logic [WIDTH:0]   step_p_d;
    logic             step_q_d;
    logic [WIDTH-1:0] mag_a_d;
    logic [WIDTH-1:0] mag_b_d;

`ifdef DIV_SIGNED_EN
    logic neg_q_q;
    logic neg_r_q;
    logic sign_a_d;
    logic sign_b_d;

    // Operand magnitudes; MIN maps onto itself, which the unsigned core
    // divides correctly as 2**(WIDTH-1).
    always_comb begin
        sign_a_d = bus.dividend[WIDTH-1];
        sign_b_d = bus.divisor[WIDTH-1];
        mag_a_d  = sign_a_d ? (~bus.dividend + 1'b1) : bus.dividend;
        mag_b_d  = sign_b_d ? (~bus.divisor + 1'b1) : bus.divisor;
    end
`else
    // Unsigned build: operands go straight into the core.
    always_comb begin
        mag_a_d = bus.dividend;
        mag_b_d = bus.divisor;
    end
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .p_i       (p_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dsr_q),
        .p_o       (step_p_d),
        .q_o       (step_q_d)
    );

    // Control FSM with datapath and registered outputs. In DONE, the first
    // cycle loads the result registers and raises out_valid; they then hold
    // until the consumer takes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            dvd_q         <= '0;
            dsr_q         <= '0;
            p_q           <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_q       <= 1'b0;
            neg_r_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_q    <= 1'b0;
                        busy_q        <= 1'b1;
                        div_by_zero_q <= (bus.divisor == '0);
                        if (bus.divisor == '0) begin
                            dvd_q   <= DZ_ALL[WIDTH-1:0];
                            p_q     <= {1'b0, bus.dividend};
                            state_q <= DONE;
                        end else begin
                            dvd_q   <= mag_a_d;
                            dsr_q   <= mag_b_d;
                            p_q     <= '0;
                            cnt_q   <= CNT_W'(WIDTH);
                            state_q <= CALC;
`ifdef DIV_SIGNED_EN
                            neg_q_q <= sign_a_d ^ sign_b_d;
                            neg_r_q <= sign_a_d;
`endif
                        end
                    end
                end
                CALC: begin
                    p_q   <= step_p_d;
                    dvd_q <= {dvd_q[WIDTH-2:0], step_q_d};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
`ifdef DIV_SIGNED_EN
                        state_q <= FIX;
`else
                        state_q <= DONE;
`endif
                    end
                end
`ifdef DIV_SIGNED_EN
                FIX: begin
                    if (neg_q_q) dvd_q <= ~dvd_q + 1'b1;
                    if (neg_r_q) p_q <= {1'b0, ~p_q[WIDTH-1:0] + 1'b1};
                    state_q <= DONE;
                end
`endif
                DONE: begin
                    if (!out_valid_q) begin
                        quotient_q  <= dvd_q;
                        remainder_q <= p_q[WIDTH-1:0];
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.busy        = busy_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_seq_divider_param.sv
// Bench for seq_divider_param: an 8-bit instance driven from a vector table,
// random operands and hand-written stall/abort sequences, plus a 16-bit
// instance for the wide case. Honours DIV_SIGNED_EN.
module tb_seq_divider_param;
  import div_pkg::*;

`ifdef DIV_SIGNED_EN
  localparam int LAT8  = 10;
  localparam int LAT16 = 18;
`else
  localparam int LAT8  = 9;
  localparam int LAT16 = 17;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec8_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_divider_param_if #(.WIDTH(8))  bus8 ();
  seq_divider_param_if #(.WIDTH(16)) bus16 ();
  div_state_e state8;
  div_state_e state16;

  seq_divider_param #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus8),
    .state_o (state8)
  );

  seq_divider_param #(.WIDTH(16)) u_dut16 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus16),
    .state_o (state16)
  );

  int checks   = 0;
  int failures = 0;
  logic [16:0] exp_q[$];   // {div_by_zero, quotient, remainder}

  // ---------------- reference model ----------------
  function automatic logic [16:0] model8(input logic [7:0] a, input logic [7:0] b);
    int q;
    int r;
    if (b == 8'h00) return {1'b1, 8'hFF, a};
`ifdef DIV_SIGNED_EN
    q = int'($signed(a)) / int'($signed(b));
    r = int'($signed(a)) % int'($signed(b));
`else
    q = int'(a) / int'(b);
    r = int'(a) % int'(b);
`endif
    return {1'b0, 8'(q), 8'(r)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && bus8.out_valid && bus8.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got dz=%0b q=0x%0h r=0x%0h expected none",
                 bus8.div_by_zero, bus8.quotient, bus8.remainder);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({bus8.div_by_zero, bus8.quotient, bus8.remainder} !== e) begin
          failures++;
          $display("FAIL sb_result: got dz=%0b q=0x%0h r=0x%0h expected dz=%0b q=0x%0h r=0x%0h",
                   bus8.div_by_zero, bus8.quotient, bus8.remainder, e[16], e[15:8], e[7:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic edz, input int stall);
    int lat;
    int bad;
    int waited;
    waited = 0;
    while (!bus8.in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("accept_ready", 32'(bus8.in_ready), 32'd1);
    bus8.in_valid = 1'b1;
    bus8.dividend = a;
    bus8.divisor  = b;
    if (stall > 0) bus8.out_ready = 1'b0;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    exp_q.push_back({edz, eq, er});
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus8.out_valid && lat < 100);
    chk("latency", 32'(lat), edz ? 32'd1 : 32'(LAT8));
    if (stall > 0) begin
      bad = 0;
      for (int i = 0; i < stall; i++) begin
        if (!(bus8.out_valid && !bus8.in_ready && bus8.busy &&
              bus8.quotient == eq && bus8.remainder == er && bus8.div_by_zero == edz))
          bad++;
        if (i == 5) begin
          bus8.in_valid = 1'b1;
          bus8.dividend = 8'h12;
          bus8.divisor  = 8'h34;
        end else begin
          bus8.in_valid = 1'b0;
        end
        @(posedge clk); #1;
      end
      bus8.in_valid = 1'b0;
      chk("stall_hold_errors", 32'(bad), 32'd0);
      bus8.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("release_valid_low", 32'(bus8.out_valid), 32'd0);
    chk("release_ready_high", 32'(bus8.in_ready), 32'd1);
    if (stall > 0) begin
      repeat (3) begin @(posedge clk); #1; end
      chk("stall_op_ignored_busy", 32'(bus8.busy), 32'd0);
    end
  endtask

  // ---------------- test sequence ----------------
  vec8_t tbl[10];

  initial begin
    int lat;
    int bad;
    logic [16:0] m;
    logic [7:0] ra;
    logic [7:0] rb;

    tbl[0] = '{8'h45, 8'h07, 8'h09, 8'h06, 1'b0};
    tbl[1] = '{8'h45, 8'h00, 8'hFF, 8'h45, 1'b1};
    tbl[2] = '{8'h64, 8'h03, 8'h21, 8'h01, 1'b0};
    tbl[3] = '{8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0};
    tbl[4] = '{8'h07, 8'h09, 8'h00, 8'h07, 1'b0};
    tbl[5] = '{8'h01, 8'h80, 8'h00, 8'h01, 1'b0};
`ifdef DIV_SIGNED_EN
    tbl[6] = '{8'hC8, 8'h0A, 8'hFB, 8'hFA, 1'b0};
    tbl[7] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0};
    tbl[8] = '{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0};
`else
    tbl[6] = '{8'hC8, 8'h0A, 8'h14, 8'h00, 1'b0};
    tbl[7] = '{8'h80, 8'hFF, 8'h00, 8'h80, 1'b0};
    tbl[8] = '{8'hF9, 8'h02, 8'h7C, 8'h01, 1'b0};
`endif
    tbl[9] = '{8'h00, 8'h00, 8'hFF, 8'h00, 1'b1};

    bus8.in_valid   = 1'b0;
    bus8.dividend   = '0;
    bus8.divisor    = '0;
    bus8.out_ready  = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.dividend  = '0;
    bus16.divisor   = '0;
    bus16.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_quotient", 32'(bus8.quotient), 32'd0);
    chk("rst_remainder", 32'(bus8.remainder), 32'd0);
    chk("rst_div_by_zero", 32'(bus8.div_by_zero), 32'd0);
    chk("rst_state", 32'(state8), 32'(IDLE));
    chk("rst16_in_ready", 32'(bus16.in_ready), 32'd1);

    // Table vectors
    for (int i = 0; i < 10; i++)
      run_op8(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, 0);

    // Stall with a competing request while the result is held
    run_op8(8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 20);

    // Reset four cycles into an operation aborts it silently
    bus8.in_valid = 1'b1;
    bus8.dividend = 8'h64;
    bus8.divisor  = 8'h03;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_busy_before_rst", 32'(bus8.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_state", 32'(state8), 32'(IDLE));
    chk("abort_in_ready", 32'(bus8.in_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus8.out_valid) bad++;
      @(posedge clk); #1;
    end
    chk("abort_no_out_valid", 32'(bad), 32'd0);
    run_op8(8'h64, 8'h03, 8'h21, 8'h01, 1'b0, 0);

    // Random operands, some with zero divisors
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 5 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      m  = model8(ra, rb);
      run_op8(ra, rb, m[15:8], m[7:0], m[16], 0);
    end

    // 16-bit instance
    bus16.in_valid = 1'b1;
    bus16.dividend = 16'hFFFF;
    bus16.divisor  = 16'h0100;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus16.out_valid && lat < 100);
    chk("w16_latency", 32'(lat), 32'(LAT16));
`ifdef DIV_SIGNED_EN
    chk("w16_quotient", 32'(bus16.quotient), 32'h0000);
    chk("w16_remainder", 32'(bus16.remainder), 32'hFFFF);
`else
    chk("w16_quotient", 32'(bus16.quotient), 32'h00FF);
    chk("w16_remainder", 32'(bus16.remainder), 32'h00FF);
`endif
    chk("w16_div_by_zero", 32'(bus16.div_by_zero), 32'd0);
    @(posedge clk); #1;
    chk("w16_release", 32'(bus16.out_valid), 32'd0);

    repeat (3) @(posedge clk);
    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_divider_param.md
Name: seq_divider_param

Overview:
- Parametrised iterative restoring divider with a valid/ready handshake on both input and output.
- Successor to the fixed 8-bit divider that sits between the keypad hex-entry path and the seven-segment display.
- Produces quotient, remainder and a divide-by-zero flag, one quotient bit per clock.
- Reusable wherever a WIDTH-bit unsigned (optionally signed) divide is needed.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), localparam: width of the iteration counter (not user-overridable).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  dividend/divisor present.
- in_ready  out  1  block accepts operands this cycle.
- dividend  in  WIDTH  numerator, sampled on in_valid && in_ready.
- divisor  in  WIDTH  denominator, sampled on in_valid && in_ready.
- out_valid  out  1  results valid.
- out_ready  in  1  consumer takes results.
- quotient  out  WIDTH  registered quotient.
- remainder  out  WIDTH  registered remainder.
- div_by_zero  out  1  registered; set when the accepted divisor was 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state to IDLE.
  - quotient, remainder, div_by_zero, out_valid to 0; in_ready to 1; busy to 0.
  - Aborts any operation in progress with no output; rst has priority over every other input.
- States: IDLE, CALC, DONE, plus FIX when DIV_SIGNED_EN is defined.
- IDLE:
  - in_ready=1.
  - On in_valid, latch operands. Divisor != 0 goes to CALC with counter=WIDTH and partial remainder P=0 ((WIDTH+1) bits). Divisor == 0 goes to DONE.
- CALC, once per cycle:
  - P' = {P[WIDTH-1:0], D[msb]}; shift D left.
  - If P' >= divisor: P = P' - divisor and shift in q=1. Otherwise P = P' and shift in q=0.
  - Decrement the counter. When it reaches 0, go to DONE (or FIX).
- DONE:
  - out_valid=1.
  - quotient, remainder and div_by_zero are held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
- Latency, unsigned: accept edge t gives out_valid at edge t+WIDTH+1, i.e. 9 cycles for WIDTH=8.
- Divide-by-zero:
  - quotient = all ones, remainder = dividend, div_by_zero=1.
  - out_valid at edge t+1.
- Throughput: in_ready is low from CALC through DONE. Accepting a new operation in the same cycle as the DONE handshake is not allowed, so there is at least one IDLE cycle between operations.
- in_valid while busy is ignored; the operands on the bus are not sampled.
- out_ready while out_valid=0 has no effect.
- div_by_zero clears when the next operation is accepted.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - Operands are two's complement. Magnitudes are taken at accept.
  - Extra FIX state (1 cycle) applies signs. Quotient sign = sign(dividend) XOR sign(divisor), truncating toward zero. Remainder takes the sign of the dividend.
  - Latency is WIDTH+2.
  - MIN / -1 gives quotient=MIN, remainder=0, no flag.
  - Divide-by-zero gives quotient=all ones, remainder=dividend.
- Undefined: purely unsigned, no FIX state, latency WIDTH+1.

Decomposition:
- Package div_pkg: state enum (IDLE, CALC, FIX, DONE) and the divide-by-zero quotient constant function (all ones of WIDTH).
- Sub-module div_step, combinational: one restoring iteration. Inputs: P, next dividend bit, divisor. Outputs: next P, quotient bit.
- Top module seq_divider_param holds the FSM, counter, operand registers and output registers.

Test Plan (WIDTH=8 unless noted):
- 0x45 / 0x07 with out_ready=1 -> after 9 cycles out_valid=1, quotient=0x09, remainder=0x06, div_by_zero=0.
- 0x45 / 0x00 -> out_valid at the next edge, quotient=0xFF, remainder=0x45, div_by_zero=1.
- 0xFF / 0x01 with out_ready held 0 for 20 cycles -> quotient=0xFF, remainder=0x00, both stable throughout; in_ready=0; a new in_valid during the stall is ignored.
- Reset asserted 4 cycles into 0x64 / 0x03 -> no out_valid. A following 0x64 / 0x03 gives quotient=0x21, remainder=0x01.
- WIDTH=16: 0xFFFF / 0x0100 -> quotient=0x00FF, remainder=0x00FF after 17 cycles.
- DIV_SIGNED_EN: 0xF9 (-7) / 0x02 -> quotient=0xFD, remainder=0xFF, latency 10.
- DIV_SIGNED_EN: 0x80 / 0xFF -> quotient=0x80, remainder=0x00.
